// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the RAM port arbiter.
//   arb_state_t : arbiter FSM encoding
//   word_t      : default-width data word
//   STREAK_W    : width of the consecutive data-grant counter
//   TIMER_W     : width of the access watchdog timer
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int STREAK_W   = 4;
  localparam int TIMER_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Access watchdog: counts stalled cycles of the current RAM access and
// flags expiry once the count reaches TIMEOUT.
//   CLK, RST : clock, synchronous active-high reset
//   clr      : hold the timer at zero (arbiter idle)
//   cnt      : advance the timer (access in progress, RAM not ready)
//   expire   : timer has reached TIMEOUT
module arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic cnt,
  output logic expire
);

  logic [TIMER_W-1:0] timer;

  assign expire = (timer == TIMER_W'(TIMEOUT));

  // Stops at TIMEOUT; the arbiter leaves the access state that same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      timer <= '0;
    end else if (clr) begin
      timer <= '0;
    end else if (cnt && !expire) begin
      timer <= timer + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the instruction-fetch and data sides.
// Data side wins arbitration unless it has taken MAX_DSTREAK grants in a
// row while a fetch was waiting. A watchdog aborts stuck accesses.
//   CLK, RST          : clock, synchronous active-high reset
//   iREN, iaddr       : fetch request / address (held until ihit)
//   ihit, iload       : fetch done pulse / fetched word
//   dREN, dWEN        : data read / write request (mutually exclusive)
//   daddr, dstore     : data address / write data
//   dhit, dload       : data done pulse / read word
//   berr              : accompanies a hit when the access timed out
//   ramREN, ramWEN    : RAM strobes
//   ramaddr, ramstore : RAM address / write data (latched)
//   ramload, ram_ready: RAM read data / access completes this cycle
//
// state | meaning
// IDLE  | arbitration; one bubble cycle between accesses
// IACC  | instruction read in progress on the RAM port
// DACC  | data read or write in progress on the RAM port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              berr,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  arb_state_t          state;
  logic [STREAK_W-1:0] streak;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   store_q;
  logic                ram_ren_q;
  logic                ram_wen_q;

  logic in_acc;
  logic expire;
  logic timed_out;
  logic done;
  logic dreq;
  logic dgrant;

  assign in_acc    = (state != IDLE);
  assign timed_out = in_acc && expire && !ram_ready;
  assign done      = in_acc && (ram_ready || expire);
  assign dreq      = dREN | dWEN;
  assign dgrant    = dreq && (!iREN || (streak < STREAK_W'(MAX_DSTREAK)));

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (!in_acc),
    .cnt    (in_acc && !ram_ready),
    .expire (expire)
  );

  // Hits follow ram_ready combinationally so the winner sees its data in
  // the completing cycle; load data is forced to zero on an aborted access.
  assign ihit  = (state == IACC) && done;
  assign dhit  = (state == DACC) && done;
  assign berr  = timed_out;
  assign iload = (ihit && !timed_out) ? ramload : '0;
  assign dload = (dhit && !timed_out) ? ramload : '0;

  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      streak    <= '0;
      addr_q    <= '0;
      store_q   <= '0;
      ram_ren_q <= 1'b0;
      ram_wen_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dgrant) begin
            state     <= DACC;
            addr_q    <= daddr;
            store_q   <= dstore;
            ram_ren_q <= !dWEN;
            ram_wen_q <= dWEN;
            // Only consecutive grants that made a fetch wait count.
            if (!iREN) begin
              streak <= '0;
            end else if (streak != STREAK_W'(MAX_DSTREAK)) begin
              streak <= streak + STREAK_W'(1);
            end
          end else if (iREN) begin
            state     <= IACC;
            addr_q    <= iaddr;
            store_q   <= '0;
            ram_ren_q <= 1'b1;
            ram_wen_q <= 1'b0;
            streak    <= '0;
          end
        end
        IACC, DACC: begin
          if (done) begin
            state     <= IDLE;
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          ram_ren_q <= 1'b0;
          ram_wen_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic [31:0] K = 32'h5A5A_0F0F;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  word_t       iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  word_t       dstore;
  logic        dhit;
  word_t       dload;
  logic        berr;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  word_t       ramstore;
  word_t       ramload;
  logic        ram_ready;

  logic [7:0]  ready_lat = 8'd0;
  logic [7:0]  acc_cnt = 8'd0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] load;
    logic        berr;
  } exp_t;

  exp_t sb[$];

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_DSTREAK (4),
    .TIMEOUT     (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .ihit      (ihit),
    .iload     (iload),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dhit      (dhit),
    .dload     (dload),
    .berr      (berr),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ram_ready (ram_ready)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM model: data is a fixed function of the address; completes after
  // ready_lat stalled cycles of the current access.
  assign ramload   = ramaddr ^ K;
  assign ram_ready = (ramREN | ramWEN) && (acc_cnt == ready_lat);

  always @(posedge CLK) begin
    acc_cnt <= (ramREN | ramWEN) ? acc_cnt + 8'd1 : 8'd0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic d, input logic [31:0] a, input logic b);
    exp_t e;
    e.is_d = d;
    e.addr = a;
    e.load = b ? 32'h0 : (a ^ K);
    e.berr = b;
    sb.push_back(e);
  endfunction

  // Monitor: pops one expectation per hit pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (berr === 1'b1 && !(ihit || dhit)) chk("berr_without_hit", 64'(berr), 64'd0);
    if (ihit === 1'b1 || dhit === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit actual ihit=%0b dhit=%0b addr=%0h required no hit", ihit, dhit, ramaddr);
      end else begin
        e = sb.pop_front();
        chk("hit_kind_d", 64'(dhit), 64'(e.is_d));
        chk("hit_kind_i", 64'(ihit), 64'(!e.is_d));
        chk("hit_addr", 64'(ramaddr), 64'(e.addr));
        chk("hit_load", 64'(e.is_d ? dload : iload), 64'(e.load));
        chk("other_load_zero", 64'(e.is_d ? iload : dload), 64'd0);
        chk("hit_berr", 64'(berr), 64'(e.berr));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_hit(input logic is_d, input string name);
    bit got = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge CLK);
      if (is_d ? dhit : ihit) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual no hit in 60 cycles required hit", name);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic i_req(input logic [31:0] a);
    iREN  = 1'b1;
    iaddr = a;
    wait_hit(1'b0, "i_req");
    iREN  = 1'b0;
  endtask

  task automatic d_req(input logic [31:0] a, input logic [31:0] s, input logic w);
    dREN   = !w;
    dWEN   = w;
    daddr  = a;
    dstore = s;
    wait_hit(1'b1, "d_req");
    dREN   = 1'b0;
    dWEN   = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc;
    RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ready_lat = 8'd0;

    // Reset: two cycles, all outputs low.
    tick();
    tick();
    @(negedge CLK);
    chk("rst_ramREN", 64'(ramREN), 0);
    chk("rst_ramWEN", 64'(ramWEN), 0);
    chk("rst_hits", 64'({ihit, dhit, berr}), 0);
    chk("rst_ramaddr", 64'(ramaddr), 0);
    chk("rst_ramstore", 64'(ramstore), 0);
    chk("rst_loads", 64'({iload, dload}), 0);

    // Single fetch with immediate ready: hit on the first IACC cycle.
    tick();
    RST = 1'b0;
    iREN = 1'b1;
    iaddr = 32'h40;
    push_exp(1'b0, 32'h40, 1'b0);
    tick();
    @(negedge CLK);
    chk("t1_ramREN", 64'(ramREN), 1);
    chk("t1_ramaddr", 64'(ramaddr), 64'h40);
    chk("t1_ihit", 64'(ihit), 1);
    chk("t1_iload", 64'(iload), 64'(32'h40 ^ K));
    tick();
    iREN = 1'b0;

    // Simultaneous requests: data first, one bubble, then fetch.
    push_exp(1'b1, 32'h100, 1'b0);
    push_exp(1'b0, 32'h80, 1'b0);
    fork
      i_req(32'h80);
      d_req(32'h100, 32'h0, 1'b0);
      begin
        for (int n = 0; n < 60; n++) begin
          @(negedge CLK);
          if (dhit) break;
        end
        @(negedge CLK);
        chk("t2_bubble_strobes", 64'({ramREN, ramWEN}), 0);
        @(negedge CLK);
        chk("t2_iacc_ramREN", 64'(ramREN), 1);
        chk("t2_iacc_ramaddr", 64'(ramaddr), 64'h80);
      end
    join

    // Streak limit: fetch held, six back-to-back writes -> D,D,D,D,I,D,D.
    for (int i = 0; i < 4; i++) push_exp(1'b1, 32'h1000 + 32'(i) * 4, 1'b0);
    push_exp(1'b0, 32'h2000, 1'b0);
    for (int i = 4; i < 6; i++) push_exp(1'b1, 32'h1000 + 32'(i) * 4, 1'b0);
    fork
      i_req(32'h2000);
      begin
        for (int i = 0; i < 6; i++) d_req(32'h1000 + 32'(i) * 4, 32'h1111_0000 + 32'(i), 1'b1);
      end
    join

    // Write with stalled RAM; address latch must ignore input changes.
    ready_lat = 8'd2;
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    push_exp(1'b1, 32'h200, 1'b0);
    tick();
    daddr = 32'h300; dstore = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("t4_ramWEN", 64'({ramWEN, ramREN}), 64'b10);
      chk("t4_ramaddr", 64'(ramaddr), 64'h200);
      chk("t4_ramstore", 64'(ramstore), 64'hDEADBEEF);
      chk("t4_dhit", 64'(dhit), 64'(k == 2));
    end
    tick();
    dWEN = 1'b0;
    @(negedge CLK);
    chk("t4_idle_strobes", 64'({ramREN, ramWEN}), 0);

    // Timeout: RAM never ready, abort on the 9th DACC cycle.
    ready_lat = 8'd255;
    dREN = 1'b1; daddr = 32'h500;
    push_exp(1'b1, 32'h500, 1'b1);
    tick();
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      cyc++;
      if (dhit) break;
    end
    chk("t5_timeout_cycle", 64'(cyc), 9);
    tick();
    dREN = 1'b0;
    @(negedge CLK);
    chk("t5_idle_after_abort", 64'({ramREN, ramWEN, dhit}), 0);

    // Reset during the 2nd IACC cycle: access lost, no hit.
    tick();
    iREN = 1'b1; iaddr = 32'h600;
    tick();
    tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_pre_rst_ramREN", 64'(ramREN), 1);
    tick();
    RST = 1'b0;
    iREN = 1'b0;
    @(negedge CLK);
    chk("t6_post_rst_ramREN", 64'(ramREN), 0);
    chk("t6_post_rst_ihit", 64'(ihit), 0);
    tick();
    ready_lat = 8'd1;
    push_exp(1'b0, 32'h700, 1'b0);
    i_req(32'h700);

    // Requester drops mid-access; access still completes with a hit.
    ready_lat = 8'd2;
    iREN = 1'b1; iaddr = 32'h740;
    push_exp(1'b0, 32'h740, 1'b0);
    tick();
    iREN = 1'b0; iaddr = 32'h0;
    wait_hit(1'b0, "t7_drop");

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
